// File: rtl/sgpr_pkg.sv
// Shared types and sizing helpers for the checkpointing register file.
package sgpr_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RESTORE = 1'b1
  } sgpr_state_e;

  // Port address width is fixed; RV32E only narrows the implemented storage.
  localparam int SGPR_PORT_AW = 5;

  function automatic int sgpr_addr_width(input int rv32e);
    return (rv32e != 0) ? 4 : 5;
  endfunction

  function automatic int sgpr_num_words(input int rv32e);
    return 1 << sgpr_addr_width(rv32e);
  endfunction

  // Chunks needed to restore words 1..num_words-1.
  function automatic int sgpr_restore_chunks(input int num_words, input int per_cycle);
    return (num_words - 1 + per_cycle - 1) / per_cycle;
  endfunction

endpackage

// File: rtl/sgpr_ckpt_restore_ctrl.sv
// Restore sequencer: checkpoint/rollback arbitration, chunked restore enables,
// and the registered ack/done/valid handshakes.
module sgpr_restore_ctrl
  import sgpr_pkg::*;
#(
  parameter int NUM_WORDS         = 32,
  parameter int RESTORE_PER_CYCLE = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ckpt_req_i,
  input  logic                 rb_req_i,
  output logic                 ckpt_take_o,
  output logic                 wr_en_o,
  output logic [NUM_WORDS-1:0] restore_en_o,
  output logic                 busy_o,
  output logic                 ckpt_ack_o,
  output logic                 rb_done_o,
  output logic                 ckpt_valid_o
);
  // state      | meaning
  // ST_IDLE    | writes and checkpoints accepted; rollback request starts restore
  // ST_RESTORE | one chunk of shadow words copied to the active bank per cycle

  localparam int N_CHUNKS = sgpr_restore_chunks(NUM_WORDS, RESTORE_PER_CYCLE);
  localparam int CW       = $clog2(NUM_WORDS + RESTORE_PER_CYCLE + 1);
  localparam int LW       = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  sgpr_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic [LW-1:0] left_q;
  logic          ack_q;
  logic          done_q;
  logic          valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      left_q  <= '0;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ack_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // Rollback wins; a simultaneous checkpoint is dropped without ack.
          if (rb_req_i) begin
            state_q <= ST_RESTORE;
            cnt_q   <= CW'(1);
            left_q  <= LW'(N_CHUNKS - 1);
          end else if (ckpt_req_i) begin
            ack_q   <= 1'b1;
            valid_q <= 1'b1;
          end
        end
        ST_RESTORE: begin
          cnt_q <= cnt_q + CW'(RESTORE_PER_CYCLE);
          if (left_q == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end else begin
            left_q <= left_q - LW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    restore_en_o = '0;
    for (int w = 1; w < NUM_WORDS; w++) begin
      if ((state_q == ST_RESTORE) && (w >= int'(cnt_q)) &&
          (w < int'(cnt_q) + RESTORE_PER_CYCLE)) begin
        restore_en_o[w] = 1'b1;
      end
    end
  end

  assign ckpt_take_o  = (state_q == ST_IDLE) && ckpt_req_i && !rb_req_i;
  assign wr_en_o      = (state_q == ST_IDLE);
  assign busy_o       = (state_q == ST_RESTORE);
  assign ckpt_ack_o   = ack_q;
  assign rb_done_o    = done_q;
  assign ckpt_valid_o = valid_q;

endmodule

// File: rtl/sgpr_ckpt.sv
// Checkpointing GPR file: active bank, single-cycle shadow capture, chunked restore.
// Optional even parity per word when SGPR_PARITY_EN is defined.
module sgpr_ckpt
  import sgpr_pkg::*;
#(
  parameter int RV32E             = 0,
  parameter int DATA_WIDTH        = 32,
  parameter int NUM_RPORTS        = 2,
  parameter int NUM_WPORTS        = 2,
  parameter int RESTORE_PER_CYCLE = 4
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_RPORTS-1:0][SGPR_PORT_AW-1:0]   raddr_i,
  output logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
  output logic [NUM_RPORTS-1:0]                     perr_o,
  input  logic [NUM_WPORTS-1:0][SGPR_PORT_AW-1:0]   waddr_i,
  input  logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_WPORTS-1:0]                     we_i,
  input  logic                                      ckpt_req_i,
  output logic                                      ckpt_ack_o,
  input  logic                                      rb_req_i,
  output logic                                      rb_done_o,
  output logic                                      busy_o,
  output logic                                      ckpt_valid_o
);

  localparam int AW = sgpr_addr_width(RV32E);
  localparam int NW = sgpr_num_words(RV32E);

  logic [DATA_WIDTH-1:0] act_q [NW];
  logic [DATA_WIDTH-1:0] act_d [NW];
  logic [DATA_WIDTH-1:0] shd_q [NW];
  logic [DATA_WIDTH-1:0] shd_d [NW];
  logic                  ckpt_take;
  logic                  wr_en;
  logic [NW-1:0]         restore_en;
  logic [NUM_WPORTS-1:0] wvalid;

  function automatic logic addr_ok(input logic [SGPR_PORT_AW-1:0] a);
    return (a != '0) && (int'(a) < NW);
  endfunction

  sgpr_restore_ctrl #(
    .NUM_WORDS         (NW),
    .RESTORE_PER_CYCLE (RESTORE_PER_CYCLE)
  ) u_ctrl (
    .clk          (clk),
    .rst_n        (rst_n),
    .ckpt_req_i   (ckpt_req_i),
    .rb_req_i     (rb_req_i),
    .ckpt_take_o  (ckpt_take),
    .wr_en_o      (wr_en),
    .restore_en_o (restore_en),
    .busy_o       (busy_o),
    .ckpt_ack_o   (ckpt_ack_o),
    .rb_done_o    (rb_done_o),
    .ckpt_valid_o (ckpt_valid_o)
  );

  always_comb begin
    wvalid = '0;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      wvalid[p] = wr_en && we_i[p] && addr_ok(waddr_i[p]);
    end
  end

  // Ascending port loop: the highest-index port writing an address wins.
  always_comb begin
    act_d = act_q;
    shd_d = shd_q;
    if (ckpt_take) shd_d = act_q;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (wvalid[p]) act_d[waddr_i[p][AW-1:0]] = wdata_i[p];
    end
    for (int w = 1; w < NW; w++) begin
      if (restore_en[w]) act_d[w] = shd_q[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < NW; w++) begin
        act_q[w] <= '0;
        shd_q[w] <= '0;
      end
    end else begin
      act_q <= act_d;
      shd_q <= shd_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (addr_ok(raddr_i[p])) rdata_o[p] = act_q[raddr_i[p][AW-1:0]];
    end
  end

`ifdef SGPR_PARITY_EN
  logic [NW-1:0] pact_q;
  logic [NW-1:0] pact_d;
  logic [NW-1:0] pshd_q;
  logic [NW-1:0] pshd_d;

  always_comb begin
    pact_d = pact_q;
    pshd_d = pshd_q;
    if (ckpt_take) pshd_d = pact_q;
    for (int p = 0; p < NUM_WPORTS; p++) begin
      if (wvalid[p]) pact_d[waddr_i[p][AW-1:0]] = ^wdata_i[p];
    end
    for (int w = 1; w < NW; w++) begin
      if (restore_en[w]) pact_d[w] = pshd_q[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pact_q <= '0;
      pshd_q <= '0;
    end else begin
      pact_q <= pact_d;
      pshd_q <= pshd_d;
    end
  end

  always_comb begin
    perr_o = '0;
    for (int p = 0; p < NUM_RPORTS; p++) begin
      if (addr_ok(raddr_i[p])) begin
        perr_o[p] = pact_q[raddr_i[p][AW-1:0]] ^ (^act_q[raddr_i[p][AW-1:0]]);
      end
    end
  end
`else
  assign perr_o = '0;
`endif

endmodule

// File: tb/tb_sgpr_ckpt.sv
// Directed + randomized bench for sgpr_ckpt against an array-level reference model.
module tb_sgpr_ckpt;

  localparam int NW  = 32;
  localparam int RPC = 4;
  localparam int NCH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [1:0][4:0]  raddr_i;
  logic [1:0][31:0] rdata_o;
  logic [1:0]       perr_o;
  logic [1:0][4:0]  waddr_i;
  logic [1:0][31:0] wdata_i;
  logic [1:0]       we_i;
  logic             ckpt_req_i, ckpt_ack_o, rb_req_i, rb_done_o, busy_o, ckpt_valid_o;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_act [NW];
  logic [31:0] m_sh  [NW];
  logic [31:0] m_pre [NW];
  logic        m_valid;
  logic        flip_v;

  sgpr_ckpt #(
    .RV32E(0), .DATA_WIDTH(32), .NUM_RPORTS(2), .NUM_WPORTS(2), .RESTORE_PER_CYCLE(RPC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .raddr_i(raddr_i), .rdata_o(rdata_o), .perr_o(perr_o),
    .waddr_i(waddr_i), .wdata_i(wdata_i), .we_i(we_i),
    .ckpt_req_i(ckpt_req_i), .ckpt_ack_o(ckpt_ack_o),
    .rb_req_i(rb_req_i), .rb_done_o(rb_done_o),
    .busy_o(busy_o), .ckpt_valid_o(ckpt_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we_i = '0;
    ckpt_req_i = 1'b0;
    rb_req_i = 1'b0;
  endtask

  // {busy, ack, done, valid}
  task automatic chk_status(input string tag, input logic [3:0] exp);
    chk(tag, {busy_o, ckpt_ack_o, rb_done_o, ckpt_valid_o}, exp);
  endtask

  task automatic rd_chk(input string tag, input int a0, input int a1,
                        input logic [31:0] e0, input logic [31:0] e1);
    raddr_i[0] = 5'(a0);
    raddr_i[1] = 5'(a1);
    #1;
    chk(tag, rdata_o[0], e0);
    chk(tag, rdata_o[1], e1);
    chk({tag, "_perr"}, perr_o, 2'b00);
  endtask

  task automatic full_chk(input string tag);
    for (int a = 0; a < NW; a += 2) rd_chk(tag, a, a + 1, m_act[a], m_act[a + 1]);
  endtask

  // Model of an accepted idle-cycle write; later ports overwrite earlier ones.
  task automatic model_write();
    for (int p = 0; p < 2; p++) begin
      if (we_i[p] && waddr_i[p] != 5'd0) m_act[waddr_i[p]] = wdata_i[p];
    end
  endtask

  task automatic rand_cycles(input int n);
    int a0, a1;
    for (int i = 0; i < n; i++) begin
      we_i       = 2'($urandom);
      waddr_i[0] = 5'($urandom);
      waddr_i[1] = ($urandom_range(0, 1) == 1) ? waddr_i[0] : 5'($urandom);
      wdata_i[0] = $urandom;
      wdata_i[1] = $urandom;
      a0 = $urandom_range(0, NW - 1);
      a1 = $urandom_range(0, NW - 1);
      rd_chk("rand_rd", a0, a1, m_act[a0], m_act[a1]);
      tick();
      model_write();
    end
    we_i = '0;
  endtask

  // Word w belongs to chunk (w-1)/RPC and is restored by the edge ending that chunk.
  function automatic logic [31:0] partial_exp(input int a, input int chunks_done);
    return (((a - 1) / RPC) + 1 <= chunks_done) ? m_sh[a] : m_pre[a];
  endfunction

  task automatic rollback(input bit with_ckpt, input bit noise);
    int a0, a1;
    rb_req_i   = 1'b1;
    ckpt_req_i = with_ckpt;
    tick();
    idle_inputs();
    for (int w = 0; w < NW; w++) m_pre[w] = m_act[w];
    for (int k = 1; k <= NCH; k++) begin
      chk_status("rb_busy", {1'b1, 1'b0, 1'b0, m_valid});
      a0 = $urandom_range(1, NW - 1);
      a1 = $urandom_range(1, NW - 1);
      rd_chk("rb_partial", a0, a1, partial_exp(a0, k - 1), partial_exp(a1, k - 1));
      if (noise) begin
        ckpt_req_i = 1'b1;
        rb_req_i   = 1'($urandom);
        we_i       = 2'b11;
        waddr_i[0] = 5'($urandom_range(1, NW - 1));
        waddr_i[1] = 5'($urandom_range(1, NW - 1));
        wdata_i[0] = $urandom;
        wdata_i[1] = $urandom;
      end
      tick();
    end
    idle_inputs();
    for (int w = 0; w < NW; w++) m_act[w] = m_sh[w];
    chk_status("rb_done", {1'b0, 1'b0, 1'b1, m_valid});
    tick();
    chk_status("rb_after", {1'b0, 1'b0, 1'b0, m_valid});
  endtask

  initial begin
    idle_inputs();
    raddr_i = '0;
    waddr_i = '0;
    wdata_i = '0;
    m_valid = 1'b0;
    for (int w = 0; w < NW; w++) begin
      m_act[w] = '0;
      m_sh[w]  = '0;
    end

    #12;
    chk_status("reset_status", 4'b0000);
    full_chk("reset_rd");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Same-address write collision and x0 write.
    we_i = 2'b11;
    waddr_i[0] = 5'd5; wdata_i[0] = 32'hA5A5A5A5;
    waddr_i[1] = 5'd5; wdata_i[1] = 32'h12345678;
    tick();
    model_write();
    we_i = '0;
    rd_chk("dual_wr", 5, 5, 32'h12345678, 32'h12345678);
    we_i = 2'b11;
    waddr_i[0] = 5'd0; wdata_i[0] = 32'hDEADBEEF;
    waddr_i[1] = 5'd0; wdata_i[1] = 32'hCAFEF00D;
    tick();
    model_write();
    we_i = '0;
    rd_chk("x0_wr", 0, 5, 32'h0, 32'h12345678);

    rand_cycles(40);

    // x_i = i, then x3 = 2, then checkpoint with a same-cycle write of x3 = 7.
    for (int i = 1; i < NW; i += 2) begin
      we_i = {1'(i + 1 < NW), 1'b1};
      waddr_i[0] = 5'(i);     wdata_i[0] = 32'(i);
      waddr_i[1] = 5'(i + 1); wdata_i[1] = 32'(i + 1);
      tick();
      model_write();
    end
    we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'd2;
    tick();
    model_write();
    ckpt_req_i = 1'b1;
    we_i = 2'b01; waddr_i[0] = 5'd3; wdata_i[0] = 32'd7;
    for (int w = 0; w < NW; w++) m_sh[w] = m_act[w];
    tick();
    model_write();
    m_valid = 1'b1;
    idle_inputs();
    chk_status("ckpt_ack", 4'b0101);
    rd_chk("ckpt_wr", 3, 4, 32'd7, 32'd4);
    tick();
    chk_status("ckpt_ack_end", 4'b0001);

    for (int i = 1; i < NW; i += 2) begin
      we_i = 2'b11;
      waddr_i[0] = 5'(i);     wdata_i[0] = 32'hFFFFFFFF;
      waddr_i[1] = 5'(i + 1); wdata_i[1] = 32'hFFFFFFFF;
      tick();
      model_write();
    end
    we_i = '0;
    rollback(1'b0, 1'b1);
    rd_chk("rb_x3", 3, 31, 32'd2, 32'd31);
    full_chk("rb_full");

    // Simultaneous checkpoint and rollback: rollback wins, shadow untouched.
    rand_cycles(20);
    rollback(1'b1, 1'b0);
    full_chk("rb_ckpt_drop");

    rand_cycles(10);
    ckpt_req_i = 1'b1;
    for (int w = 0; w < NW; w++) m_sh[w] = m_act[w];
    tick();
    idle_inputs();
    chk_status("ckpt2_ack", 4'b0101);
    rand_cycles(10);
    rollback(1'b0, 1'b1);
    full_chk("rb2_full");

    // Asynchronous reset in the fourth restore cycle.
    rand_cycles(5);
    rb_req_i = 1'b1;
    tick();
    idle_inputs();
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_valid = 1'b0;
    for (int w = 0; w < NW; w++) begin
      m_act[w] = '0;
      m_sh[w]  = '0;
    end
    chk_status("rst_mid_status", 4'b0000);
    rd_chk("rst_mid_rd", $urandom_range(1, NW - 1), $urandom_range(1, NW - 1), 32'h0, 32'h0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_status("rst_no_done", 4'b0000);
    end
    full_chk("rst_rd");

    // Rollback with no checkpoint ever taken restores zeros.
    rand_cycles(15);
    rollback(1'b0, 1'b0);
    full_chk("rb_zero");

`ifdef SGPR_PARITY_EN
    we_i = 2'b01; waddr_i[0] = 5'd9; wdata_i[0] = 32'h13579BDF;
    tick();
    model_write();
    we_i = '0;
    flip_v = ~dut.pact_q[9];
    force dut.pact_q[9] = flip_v;
    raddr_i[0] = 5'd9;
    raddr_i[1] = 5'd10;
    #1;
    chk("perr_flip", perr_o[0], 1'b1);
    chk("perr_clean", perr_o[1], 1'b0);
    release dut.pact_q[9];
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
